// File: rtl/imgproc_param_if.sv
// Read/write bus between imgproc_param and its source and result memories.
// The master modport is the engine side; the slave modport is the memory side.
interface imgproc_param_if #(
  parameter int DW = 8,
  parameter int AW = 14
);
  logic          request;
  logic [AW-1:0] orig_addr;
  logic          orig_ready;
  logic [DW-1:0] orig_data;
  logic          imgproc_ready;
  logic [AW-1:0] imgproc_addr;
  logic [DW-1:0] imgproc_data;

  modport master (
    output request, orig_addr,
    input  orig_ready, orig_data,
    output imgproc_ready, imgproc_addr, imgproc_data
  );

  modport slave (
    input  request, orig_addr,
    output orig_ready, orig_data,
    input  imgproc_ready, imgproc_addr, imgproc_data
  );
endinterface

// File: rtl/imgproc_param.sv
// Parametrised image engine: copy, invert, h-mirror or h-average of a source image.
// Optional result checksum port is built when IMGPROC_CHECKSUM_EN is defined.
module imgproc_param #(
  parameter int IMG_W = 128,
  parameter int IMG_H = 128,
  parameter int DW    = 8,
  parameter int AW    = 14
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [1:0]           mode,
  imgproc_param_if.master      bus,
  output logic                 busy,
  output logic                 finish
`ifdef IMGPROC_CHECKSUM_EN
  ,
  output logic [15:0]          checksum
`endif
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WRITE,
    S_WLAST,
    S_DONE
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic [CW-1:0] c_q;
  logic [RW-1:0] r_q;
  logic [AW-1:0] row_base;
  logic [1:0]    mode_q;
  logic [DW-1:0] cur_q;
  logic [DW-1:0] prev_q;

  logic          go;
  logic          adv;
  logic          col_last;
  logic          row_last;
  logic          m3;
  logic          cap;
  logic [CW-1:0] col_rev;
  logic [AW-1:0] src_addr;
  logic          wr;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic [DW:0]   sum_w;

  assign go       = start && (state_q == S_IDLE || state_q == S_DONE);
  assign col_last = c_q == CW'(IMG_W - 1);
  assign row_last = r_q == RW'(IMG_H - 1);
  assign m3       = mode_q == 2'd3;
  assign cap      = state_q == S_FETCH && bus.orig_ready;
  assign col_rev  = CW'(IMG_W - 1) - c_q;
  assign src_addr = row_base + AW'((mode_q == 2'd2) ? col_rev : c_q);
  assign sum_w    = {1'b0, prev_q} + {1'b0, cur_q} + (DW + 1)'(1);

  // State register; a reset mid-pass drops straight back to IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next state plus the scan-advance strobe for the counters.
  always_comb begin
    state_d = state_q;
    adv     = 1'b0;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (go) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (bus.orig_ready)
          state_d = (m3 && c_q == '0) ? S_FETCH : S_WRITE;
      end
      S_WRITE: begin
        if (m3 && col_last) begin
          state_d = S_WLAST;
        end else begin
          adv     = 1'b1;
          state_d = (col_last && row_last) ? S_DONE : S_FETCH;
        end
      end
      S_WLAST: begin
        adv     = 1'b1;
        state_d = row_last ? S_DONE : S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Scan counters, row base, latched mode and captured pixels.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_q      <= '0;
      r_q      <= '0;
      row_base <= '0;
      mode_q   <= '0;
      cur_q    <= '0;
      prev_q   <= '0;
    end else if (go) begin
      c_q      <= '0;
      r_q      <= '0;
      row_base <= '0;
      mode_q   <= mode;
    end else begin
      if (cap) begin
        cur_q <= bus.orig_data;
        if (m3 && c_q == '0) begin
          prev_q <= bus.orig_data;
          c_q    <= c_q + CW'(1);
        end
      end
      if (state_q == S_WRITE && m3)
        prev_q <= cur_q;
      if (adv) begin
        if (col_last) begin
          c_q <= '0;
          if (!row_last) begin
            r_q      <= r_q + RW'(1);
            row_base <= row_base + AW'(IMG_W);
          end
        end else begin
          c_q <= c_q + CW'(1);
        end
      end
    end
  end

  // Result pixel: the average lands one column behind the fetch in mode 3.
  always_comb begin
    wr    = state_q == S_WRITE || state_q == S_WLAST;
    waddr = row_base + AW'(c_q);
    wdata = cur_q;
    if (state_q == S_WRITE) begin
      unique case (mode_q)
        2'd1: wdata = ~cur_q;
        2'd3: begin
          wdata = DW'(sum_w >> 1);
          waddr = row_base + AW'(c_q) - AW'(1);
        end
        default: wdata = cur_q;
      endcase
    end
  end

  assign bus.request       = state_q == S_FETCH;
  assign bus.orig_addr     = bus.request ? src_addr : '0;
  assign bus.imgproc_ready = wr;
  assign bus.imgproc_addr  = wr ? waddr : '0;
  assign bus.imgproc_data  = wr ? wdata : '0;
  assign busy   = state_q == S_FETCH || state_q == S_WRITE ||
                  state_q == S_WLAST;
  assign finish = state_q == S_DONE;

`ifdef IMGPROC_CHECKSUM_EN
  // Running sum of every written pixel, restarted with each pass.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     checksum <= '0;
    else if (go) checksum <= '0;
    else if (wr) checksum <= checksum + 16'(wdata);
  end
`endif

endmodule

// File: tb/tb_imgproc_param.sv
// Scoreboard bench for imgproc_param on an 8x4 image.
// Memory responder has random latency; writes are checked against a model queue.
module tb_imgproc_param;
  localparam int W  = 8;
  localparam int H  = 4;
  localparam int N  = W * H;
  localparam int AW = 5;
  localparam int DW = 8;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [1:0] mode = 2'd0;
  logic       busy;
  logic       finish;
`ifdef IMGPROC_CHECKSUM_EN
  logic [15:0] checksum;
`endif

  imgproc_param_if #(.DW(DW), .AW(AW)) bus ();

  imgproc_param #(
    .IMG_W(W), .IMG_H(H), .DW(DW), .AW(AW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .mode(mode),
    .bus(bus.master),
    .busy(busy),
    .finish(finish)
`ifdef IMGPROC_CHECKSUM_EN
    ,
    .checksum(checksum)
`endif
  );

  always #5 clk = ~clk;

  wr_t           exp_q[$];
  logic [AW-1:0] fexp_q[$];
  logic [7:0]    src[N];
  logic [7:0]    res[N];
  int            n_chk = 0;
  int            n_err = 0;
  int            nwr = 0;
  int            maxlat = 1;
  int            exp_sum = 0;
  bit            armed = 1'b0;
  int            lat_left = 0;
  logic [AW-1:0] req_addr;
  wr_t           mon_e;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Memory responder and write monitor, both sampled on the falling edge.
  always @(negedge clk) begin
    if (bus.imgproc_ready) begin
      nwr++;
      res[bus.imgproc_addr] = bus.imgproc_data;
      if (exp_q.size() == 0) begin
        chk("extra_wr", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wr_addr", 32'(bus.imgproc_addr), 32'(mon_e.a));
        chk("wr_data", 32'(bus.imgproc_data), 32'(mon_e.d));
      end
    end
    if (bus.orig_ready) begin
      bus.orig_ready = 1'b0;
      armed = 1'b0;
    end
    if (rst) begin
      armed = 1'b0;
    end else if (bus.request) begin
      if (!armed) begin
        armed    = 1'b1;
        req_addr = bus.orig_addr;
        lat_left = int'($urandom_range(1, maxlat));
        if (fexp_q.size() == 0) chk("extra_fetch", 1, 0);
        else chk("fetch_addr", 32'(bus.orig_addr), 32'(fexp_q.pop_front()));
      end else begin
        chk("addr_stable", 32'(bus.orig_addr), 32'(req_addr));
      end
      lat_left--;
      if (lat_left == 0) begin
        bus.orig_ready = 1'b1;
        bus.orig_data  = src[bus.orig_addr];
      end
    end
  end

  task automatic load_exp(input logic [1:0] m);
    wr_t e;
    int  a;
    int  v;
    exp_sum = 0;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        a = r * W + c;
        case (m)
          2'd0: v = src[a];
          2'd1: v = 255 - src[a];
          2'd2: v = src[r * W + W - 1 - c];
          default: v = (c == W - 1) ? src[a] : (src[a] + src[a + 1] + 1) / 2;
        endcase
        e.a = AW'(a);
        e.d = DW'(v);
        exp_q.push_back(e);
        fexp_q.push_back(AW'((m == 2'd2) ? r * W + W - 1 - c : a));
        exp_sum += v;
      end
    end
    nwr = 0;
  endtask

  task automatic run_pass(input logic [1:0] m, input bit poke);
    int cyc;
    load_exp(m);
    @(negedge clk);
    start = 1'b1;
    mode  = m;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 1);
    chk("finish_drop", 32'(finish), 0);
`ifdef IMGPROC_CHECKSUM_EN
    chk("cs_cleared", 32'(checksum), 0);
`endif
    cyc = 1;
    while (!finish && cyc < 4000) begin
      if (poke && cyc == 20) begin
        start = 1'b1;
        mode  = m + 2'd1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    chk("finish_timeout", 32'(finish), 1);
    if (maxlat == 1) chk("finish_latency", 32'(cyc <= 3 * N + 4), 1);
    chk("strobe_count", 32'(nwr), 32'(N));
    chk("exp_empty", 32'(exp_q.size()), 0);
    chk("busy_done", 32'(busy), 0);
`ifdef IMGPROC_CHECKSUM_EN
    chk("checksum", 32'(checksum), 32'(exp_sum[15:0]));
`endif
    repeat (3) @(negedge clk);
    chk("finish_held", 32'(finish), 1);
    chk("no_wr_in_done", 32'(nwr), 32'(N));
  endtask

  initial begin
    int cyc;
    int nwr0;
    logic [7:0] row0[W];
    row0[0] = 8'd10;
    row0[1] = 8'd11;
    row0[2] = 8'd255;
    for (int i = 3; i < W - 1; i++) row0[i] = 8'd0;
    row0[W - 1] = 8'd77;
    bus.orig_ready = 1'b0;
    bus.orig_data  = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_request", 32'(bus.request), 0);
    chk("rst_oaddr", 32'(bus.orig_addr), 0);
    chk("rst_wstrobe", 32'(bus.imgproc_ready), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_finish", 32'(finish), 0);
    rst = 1'b0;

    for (int i = 0; i < N; i++) src[i] = 8'(i);
    run_pass(2'd0, 1'b0);

    for (int i = 0; i < N; i++)
      src[i] = (i % 3 == 0) ? 8'h00 : (i % 3 == 1) ? 8'h5A : 8'hFF;
    run_pass(2'd1, 1'b0);
    chk("inv_00", 32'(res[0]), 32'hFF);
    chk("inv_5a", 32'(res[1]), 32'hA5);
    chk("inv_ff", 32'(res[2]), 32'h00);

    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) src[r * W + c] = 8'(r * 16 + c);
    run_pass(2'd2, 1'b0);
    chk("mir_r1c0", 32'(res[W]), 32'd23);
    chk("mir_r3c7", 32'(res[3 * W + 7]), 32'd48);

    for (int i = 0; i < N; i++) src[i] = 8'($urandom_range(0, 255));
    for (int c = 0; c < W; c++) src[c] = row0[c];
    src[W] = 8'd200;
    run_pass(2'd3, 1'b1);
    chk("avg_c0", 32'(res[0]), 32'd11);
    chk("avg_c1", 32'(res[1]), 32'd133);
    chk("avg_c2", 32'(res[2]), 32'd128);
    chk("avg_c6", 32'(res[W - 2]), 32'd39);
    chk("avg_last", 32'(res[W - 1]), 32'd77);

    maxlat = 5;
    for (int i = 0; i < N; i++) src[i] = 8'(i * 7 + 3);
    run_pass(2'd0, 1'b0);

    load_exp(2'd0);
    @(negedge clk);
    start = 1'b1;
    mode  = 2'd0;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (nwr < 10 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    chk("reach_px10", 32'(nwr >= 10), 1);
    #1 rst = 1'b1;
    #1;
    chk("arst_request", 32'(bus.request), 0);
    chk("arst_oaddr", 32'(bus.orig_addr), 0);
    chk("arst_wstrobe", 32'(bus.imgproc_ready), 0);
    chk("arst_waddr", 32'(bus.imgproc_addr), 0);
    chk("arst_wdata", 32'(bus.imgproc_data), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_finish", 32'(finish), 0);
`ifdef IMGPROC_CHECKSUM_EN
    chk("arst_checksum", 32'(checksum), 0);
`endif
    exp_q.delete();
    fexp_q.delete();
    nwr0 = nwr;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("no_wr_after_rst", 32'(nwr), 32'(nwr0));
    chk("idle_after_rst", 32'(busy), 0);
    run_pass(2'd0, 1'b0);

    maxlat = 1;
    run_pass(2'd1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
